// File: rtl/fetch_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// fetch_sequencer_if
//------------------------------------------------------------------------------
// Purpose : Bundles the branch-logic, instruction-memory and decode signals
//           of the fetch sequencer into one interface.
// Modports:
//   master - the fetch sequencer itself (owns pc/lr/instr/retired and the
//            request side of the instruction-memory handshake)
//   slave  - the environment (branch logic, instruction memory, decode)
// Signals :
//   pc, lr          16  current PC / link register
//   pcnext, lrnext  16  next PC / LR from branch logic
//   advance          1  decode finished with the held instruction
//   imem_req         1  fetch request valid
//   imem_addr       16  fetch address (mirror of pc)
//   imem_ready       1  memory accepts the request
//   imem_valid       1  response data valid
//   imem_rdata      16  response instruction word
//   instr           16  held instruction word
//   instr_valid      1  instr valid, awaiting advance
//   retired         16  committed-instruction count (wrapping)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface fetch_sequencer_if;
   logic [15:0] pc;
   logic [15:0] lr;
   logic [15:0] pcnext;
   logic [15:0] lrnext;
   logic        advance;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] retired;

   modport master (
      output pc,
      output lr,
      input  pcnext,
      input  lrnext,
      input  advance,
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_valid,
      input  imem_rdata,
      output instr,
      output instr_valid,
      output retired
   );

   modport slave (
      input  pc,
      input  lr,
      output pcnext,
      output lrnext,
      output advance,
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_valid,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      input  retired
   );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// fetch_sequencer
//------------------------------------------------------------------------------
// Purpose : Instruction-fetch sequencer. Owns the architectural PC and LR,
//           fetches the instruction at PC over a request/response memory
//           handshake, holds it for decode and, when decode signals advance,
//           commits the branch logic's pcnext/lrnext and fetches again.
// Ports   :
//   clk    in   single clock, rising-edge
//   reset  in   asynchronous active-high reset
//   bus    master modport of fetch_sequencer_if (branch logic, imem, decode)
// Params  :
//   RESET_PC  PC value loaded on reset
//   RESET_LR  LR value loaded on reset
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] RESET_LR = 16'h0000
) (
   input  wire logic           clk,
   input  wire logic           reset,
   fetch_sequencer_if.master   bus
);

   // IDLE is only reachable through reset; REQ/WAIT/HOLD form the
   // steady-state fetch loop with exactly one transaction in flight.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]  state_q,   state_d;
   logic [15:0] pc_q,      pc_d;
   logic [15:0] lr_q,      lr_d;
   logic [15:0] instr_q,   instr_d;
   logic [15:0] retired_q, retired_d;

   // Next-state logic. Handshake inputs are only looked at in the state
   // that owns them, so a stray imem_valid or advance elsewhere is inert.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      lr_d      = lr_q;
      instr_d   = instr_q;
      retired_d = retired_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            // A response in the acceptance cycle is deliberately not
            // captured: the memory may only answer from the next cycle on.
            if (bus.imem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_valid) begin
               instr_d = bus.imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            // Commit point: pcnext/lrnext are sampled only here, so the
            // branch logic sees constant pc/lr for the whole decode window.
            if (bus.advance) begin
               pc_d      = bus.pcnext;
               lr_d      = bus.lrnext;
               retired_d = retired_q + 16'd1;
               state_d   = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         lr_q      <= RESET_LR;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         lr_q      <= lr_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   // Request and valid flags are pure state decodes, so they drop to zero
   // the instant reset is applied.
   assign bus.pc          = pc_q;
   assign bus.lr          = lr_q;
   assign bus.imem_addr   = pc_q;
   assign bus.imem_req    = (state_q == S_REQ);
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state_q == S_HOLD);
   assign bus.retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_fetch_sequencer
//------------------------------------------------------------------------------
// Purpose : Directed self-checking bench for fetch_sequencer with
//           RESET_PC=16'h0040. Inputs change 1ns after the rising edge and
//           outputs are observed at that same point.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC (16'h0040),
      .RESET_LR (16'h0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.pc !== 16'h0040) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.pc, 16'h0040); end
      checks++; if (bus.lr !== 16'h0000) begin errors++; $display("FAIL rst_lr got %h exp %h", bus.lr, 16'h0000); end
      checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp %h", bus.instr, 16'h0000); end
      checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL rst_retired got %h exp %h", bus.retired, 16'h0000); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got %b exp 0", bus.instr_valid); end
      step();
      reset = 1'b0;
      // first cycle after release: IDLE
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
      step();
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL first_addr got %h exp %h", bus.imem_addr, 16'h0040); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL first_ivalid got %b exp 0", bus.instr_valid); end
   endtask

   // Zero-wait memory, advance held high, pcnext = pc + 1.
   task automatic test_zero_wait();
      logic [15:0] addr_exp;
      logic [15:0] data_exp;
      bus.imem_ready = 1'b1;
      bus.imem_valid = 1'b1;
      bus.advance    = 1'b1;
      bus.lrnext     = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         addr_exp = 16'h0040 + 16'(i);
         data_exp = 16'hC000 + 16'(i);
         bus.imem_rdata = data_exp;
         bus.pcnext     = addr_exp + 16'd1;
         checks++; if (bus.imem_addr !== addr_exp) begin errors++; $display("FAIL zw_addr[%0d] got %h exp %h", i, bus.imem_addr, addr_exp); end
         step(); // WAIT
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_wait_req[%0d] got %b exp 0", i, bus.imem_req); end
         step(); // HOLD
         checks++; if (bus.instr !== data_exp) begin errors++; $display("FAIL zw_instr[%0d] got %h exp %h", i, bus.instr, data_exp); end
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL zw_ivalid[%0d] got %b exp 1", i, bus.instr_valid); end
         step(); // REQ at new pc
         checks++; if (bus.retired !== 16'(i + 1)) begin errors++; $display("FAIL zw_retired[%0d] got %h exp %h", i, bus.retired, 16'(i + 1)); end
         checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL zw_req_after[%0d] got req=%b iv=%b exp req=1 iv=0", i, bus.imem_req, bus.instr_valid); end
         checks++; if (bus.pc !== addr_exp + 16'd1) begin errors++; $display("FAIL zw_pc[%0d] got %h exp %h", i, bus.pc, addr_exp + 16'd1); end
      end
      bus.imem_ready = 1'b0;
      bus.imem_valid = 1'b0;
      bus.advance    = 1'b0;
   endtask

   // ready low for 4 cycles, response 2 cycles after acceptance.
   task automatic test_stall();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0043) begin errors++; $display("FAIL stall_req[%0d] got req=%b addr=%h exp req=1 addr=0043", i, bus.imem_req, bus.imem_addr); end
      end
      bus.imem_ready = 1'b1;
      step(); // accepted -> WAIT
      bus.imem_ready = 1'b0;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_wait_req got %b exp 0", bus.imem_req); end
      step(); // still WAIT, no response yet
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stall_wait_iv got %b exp 0", bus.instr_valid); end
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'hA5C3;
      step(); // HOLD
      bus.imem_valid = 1'b0;
      checks++; if (bus.instr !== 16'hA5C3) begin errors++; $display("FAIL stall_instr got %h exp A5C3", bus.instr); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_iv got %b exp 1", bus.instr_valid); end
   endtask

   task automatic test_spurious_valid_hold();
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      step();
      bus.imem_valid = 1'b0;
      checks++; if (bus.instr !== 16'hA5C3) begin errors++; $display("FAIL hold_spur_instr got %h exp A5C3", bus.instr); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_spur_state got iv=%b req=%b exp iv=1 req=0", bus.instr_valid, bus.imem_req); end
   endtask

   task automatic test_jump_link();
      bus.pcnext  = 16'h1200;
      bus.lrnext  = 16'h0041;
      bus.advance = 1'b1;
      step(); // REQ at 1200
      checks++; if (bus.pc !== 16'h1200 || bus.lr !== 16'h0041) begin errors++; $display("FAIL jl_commit got pc=%h lr=%h exp pc=1200 lr=0041", bus.pc, bus.lr); end
      checks++; if (bus.imem_addr !== 16'h1200 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL jl_req got req=%b addr=%h exp req=1 addr=1200", bus.imem_req, bus.imem_addr); end
      checks++; if (bus.retired !== 16'h0004) begin errors++; $display("FAIL jl_retired got %h exp 0004", bus.retired); end
      // spurious advance plus spurious response in REQ
      bus.pcnext     = 16'hBEEF;
      bus.lrnext     = 16'hBEEF;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      step();
      checks++; if (bus.pc !== 16'h1200 || bus.lr !== 16'h0041) begin errors++; $display("FAIL req_spur_pclr got pc=%h lr=%h exp pc=1200 lr=0041", bus.pc, bus.lr); end
      checks++; if (bus.instr !== 16'hA5C3 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL req_spur_instr got instr=%h req=%b exp instr=A5C3 req=1", bus.instr, bus.imem_req); end
      // response in the acceptance cycle is ignored
      bus.imem_ready = 1'b1;
      step(); // WAIT
      bus.imem_ready = 1'b0;
      bus.imem_valid = 1'b0;
      checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'hA5C3) begin errors++; $display("FAIL accept_valid got iv=%b instr=%h exp iv=0 instr=A5C3", bus.instr_valid, bus.instr); end
      // advance in WAIT with no response
      step();
      checks++; if (bus.pc !== 16'h1200 || bus.lr !== 16'h0041) begin errors++; $display("FAIL wait_spur_pclr got pc=%h lr=%h exp pc=1200 lr=0041", bus.pc, bus.lr); end
      checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_spur_state got iv=%b req=%b exp 0 0", bus.instr_valid, bus.imem_req); end
      bus.advance    = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'h1234;
      step(); // HOLD
      bus.imem_valid = 1'b0;
      checks++; if (bus.instr !== 16'h1234 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL jl_instr got instr=%h iv=%b exp 1234 1", bus.instr, bus.instr_valid); end
   endtask

   task automatic test_reset_mid_wait();
      bus.pcnext  = 16'h1201;
      bus.lrnext  = 16'h0041;
      bus.advance = 1'b1;
      step(); // REQ, retired=5
      bus.advance    = 1'b0;
      bus.imem_ready = 1'b1;
      step(); // WAIT
      bus.imem_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.pc !== 16'h0040 || bus.lr !== 16'h0000) begin errors++; $display("FAIL arst_pclr got pc=%h lr=%h exp 0040 0000", bus.pc, bus.lr); end
      checks++; if (bus.instr !== 16'h0000 || bus.retired !== 16'h0000) begin errors++; $display("FAIL arst_instr_ret got instr=%h ret=%h exp 0000 0000", bus.instr, bus.retired); end
      checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL arst_flags got req=%b iv=%b exp 0 0", bus.imem_req, bus.instr_valid); end
      step();
      reset = 1'b0;
      // late response lands in IDLE and then REQ
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      step(); // REQ
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL refetch got req=%b addr=%h exp 1 0040", bus.imem_req, bus.imem_addr); end
      step();
      bus.imem_valid = 1'b0;
      checks++; if (bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL late_drop got instr=%h iv=%b exp 0000 0", bus.instr, bus.instr_valid); end
   endtask

   task automatic test_retired_wrap();
      bus.imem_ready = 1'b1;
      step(); // WAIT
      bus.imem_ready = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'h7777;
      step(); // HOLD
      bus.imem_valid = 1'b0;
      force dut.retired_q = 16'hFFFF;
      #1;
      release dut.retired_q;
      bus.pcnext  = 16'h0041;
      bus.lrnext  = 16'h0000;
      bus.advance = 1'b1;
      step();
      bus.advance = 1'b0;
      checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", bus.retired); end
      checks++; if (bus.pc !== 16'h0041 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc got pc=%h req=%b exp 0041 1", bus.pc, bus.imem_req); end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      bus.pcnext     = 16'h0000;
      bus.lrnext     = 16'h0000;
      bus.advance    = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 16'h0000;
      test_reset();
      test_zero_wait();
      test_stall();
      test_spurious_valid_hold();
      test_jump_link();
      test_reset_mid_wait();
      test_retired_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that owns the architectural PC and LR registers on the consumer side of the branch logic. It presents the current `pc`/`lr` to the branch logic, fetches the instruction at `pc` over a request/response instruction-memory handshake, and holds it for decode. When decode signals completion, it commits the branch logic's `pcnext`/`lrnext` and starts the next fetch.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `RESET_LR`, default 16'h0000: LR value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  out  16  current PC, fed to branch logic and used as the fetch address.
- `lr`  out  16  current link register, fed to branch logic.
- `pcnext`  in  16  next PC from branch logic.
- `lrnext`  in  16  next LR from branch logic.
- `advance`  in  1  decode has finished the held instruction; commit `pcnext`/`lrnext`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch address, always equal to `pc`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_valid`  in  1  response data valid.
- `imem_rdata`  in  16  response instruction word.
- `instr`  out  16  held instruction word.
- `instr_valid`  out  1  `instr` is valid and awaiting `advance`.
- `retired`  out  16  count of committed instructions, wraps at 16'hFFFF→16'h0000.

## Operation
- States:
  - **IDLE**: entered only from reset. Always moves to REQ on the next edge.
  - **REQ**: `imem_req`=1. If `imem_ready`=1, the request handshake completes and the block moves to WAIT. Otherwise it stays in REQ, holding the request and address stable.
  - **WAIT**: `imem_req`=0. If `imem_valid`=1, `instr` <= `imem_rdata` and the block moves to HOLD.
  - **HOLD**: `instr_valid`=1. If `advance`=1: `pc` <= `pcnext`, `lr` <= `lrnext`, `retired` <= `retired`+1, and the block moves to REQ.
- Exactly one outstanding fetch at a time. A second request is never issued before the response arrives.
- `imem_valid` is ignored in IDLE, REQ and HOLD. `imem_ready` is ignored outside REQ.
- `advance` is ignored outside HOLD. `pcnext`/`lrnext` are sampled only on the HOLD+`advance` edge.
- `pc`, `lr` and `instr` are stable from the commit edge until the next commit, or the next response for `instr`. The branch logic therefore sees constant inputs throughout decode.
- `imem_addr` is combinationally equal to `pc`. `instr_valid` is decoded from the state, not separately registered.
- Arithmetic: `retired` is a 16-bit unsigned increment with no saturation. `pc`/`lr` are loaded verbatim; no increment happens here.

## Timing
- Reset, asynchronous and immediate: state=IDLE, `pc`=RESET_PC, `lr`=RESET_LR, `instr`=16'h0000, `retired`=0, `imem_req`=0, `instr_valid`=0.
- First `imem_req` is asserted in the 2nd cycle after `reset` deasserts: one cycle in IDLE, then REQ.
- Minimum instruction period is 3 cycles (REQ, WAIT, HOLD), given `imem_ready` on the first REQ cycle, `imem_valid` on the first WAIT cycle, and `advance` on the first HOLD cycle.
- `instr_valid` rises the cycle after `imem_valid` is sampled in WAIT. It falls the cycle after `advance` is sampled in HOLD. `imem_req` rises in that same cycle, with `imem_addr` = new `pc`.
- A response arriving in the same cycle as request acceptance (REQ with `imem_ready` and `imem_valid` both high) is ignored. The memory must respond no earlier than the cycle after acceptance.
- Reset mid-fetch (REQ or WAIT) aborts the transaction. A late `imem_valid` after reset falls in IDLE/REQ and is dropped.
- Reset in HOLD discards `instr`; `retired` is not incremented.

## Test plan
- Reset release with RESET_PC=16'h0040: IDLE 1 cycle, then `imem_req`=1 with `imem_addr`=16'h0040; all other outputs at reset values.
- Zero-wait memory, `advance` held high, `pcnext`=`pc`+1: instructions fetched from 0040, 0041, 0042 at 3-cycle spacing; `retired` reads 1, 2, 3.
- `imem_ready` low for 4 cycles, then `imem_valid` 2 cycles after acceptance: `imem_req`/`imem_addr` stable across the stall, and `instr` = `imem_rdata` (e.g. 16'hA5C3) with `instr_valid` high one cycle later.
- Jump-link commit in HOLD with `pcnext`=16'h1200, `lrnext`=16'h0041: next cycle `pc`=16'h1200, `lr`=16'h0041, and `imem_addr`=16'h1200. A spurious `advance` pulse in REQ/WAIT leaves `pc`/`lr` unchanged.
- Spurious `imem_valid` with rdata=16'hDEAD in REQ and HOLD: `instr` is unchanged and no state change occurs.
- Reset asserted mid-WAIT, then a response arrives after release: outputs return to reset values asynchronously, the response is dropped, and the refetch targets RESET_PC. `retired` wrap from 16'hFFFF on `advance` gives 16'h0000.
